// File: rtl/axi4_lite_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite master.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WIdle = 2'b00,
    WSend = 2'b01,
    WResp = 2'b10
  } wr_state_e;

  typedef enum logic [1:0] {
    RIdle = 2'b00,
    RAddr = 2'b01,
    RData = 2'b10
  } rd_state_e;

  // True for SLVERR/DECERR; handy for callers deciding how to report a failure.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// Single-beat AXI4-Lite master. Independent write and read FSMs; every output is a flop.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  // User write command
  input  logic                      iWR_REQ,
  input  logic [ADDR_WIDTH-1:0]     iWR_ADDR,
  input  logic [DATA_WIDTH-1:0]     iWR_DATA,
  input  logic [DATA_WIDTH/8-1:0]   iWR_STRB,
  output logic                      oWR_BUSY,
  output logic                      oWR_DONE,
  output logic [1:0]                oWR_RESP,
  // User read command
  input  logic                      iRD_REQ,
  input  logic [ADDR_WIDTH-1:0]     iRD_ADDR,
  output logic                      oRD_BUSY,
  output logic                      oRD_DONE,
  output logic [DATA_WIDTH-1:0]     oRD_DATA,
  output logic [1:0]                oRD_RESP,
  // Write address channel
  output logic                      m_AWVALID,
  output logic [ADDR_WIDTH-1:0]     m_AWADDR,
  output logic [2:0]                m_AWPROT,
  input  logic                      m_AWREADY,
  // Write data channel
  output logic                      m_WVALID,
  output logic [DATA_WIDTH-1:0]     m_WDATA,
  output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
  input  logic                      m_WREADY,
  // Write response channel
  output logic                      m_BREADY,
  input  logic                      m_BVALID,
  input  logic [1:0]                m_BRESP,
  // Read address channel
  output logic                      m_ARVALID,
  output logic [ADDR_WIDTH-1:0]     m_ARADDR,
  output logic [2:0]                m_ARPROT,
  input  logic                      m_ARREADY,
  // Read data channel
  output logic                      m_RREADY,
  input  logic                      m_RVALID,
  input  logic [DATA_WIDTH-1:0]     m_RDATA,
  input  logic [1:0]                m_RRESP
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  wr_state_e               wr_state_q, wr_state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    wr_busy_q, wr_busy_d;
  logic                    wr_done_q, wr_done_d;
  logic [1:0]              wr_resp_q, wr_resp_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;

  // A channel is still outstanding if VALID is up and the slave has not taken it this cycle.
  logic aw_pending;
  logic w_pending;

  assign aw_pending = awvalid_q && !m_AWREADY;
  assign w_pending  = wvalid_q && !m_WREADY;

  // Write FSM next-state: AW and W retire independently, B is accepted once both are gone.
  always_comb begin
    wr_state_d = wr_state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    wr_busy_d  = wr_busy_q;
    wr_done_d  = 1'b0;
    wr_resp_d  = wr_resp_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;

    unique case (wr_state_q)
      WIdle: begin
        if (iWR_REQ) begin
          awaddr_d   = iWR_ADDR;
          wdata_d    = iWR_DATA;
          wstrb_d    = iWR_STRB;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_busy_d  = 1'b1;
          wr_state_d = WSend;
        end
      end
      WSend: begin
        if (awvalid_q && m_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && m_WREADY)   wvalid_d  = 1'b0;
        if (!aw_pending && !w_pending) begin
          bready_d   = 1'b1;
          wr_state_d = WResp;
        end
      end
      WResp: begin
        // BREADY is always high in this state, so BVALID alone is the handshake.
        if (m_BVALID) begin
          wr_resp_d  = m_BRESP;
          bready_d   = 1'b0;
          wr_busy_d  = 1'b0;
          wr_done_d  = 1'b1;
          wr_state_d = WIdle;
        end
      end
      default: begin
        wr_state_d = WIdle;
      end
    endcase
  end

  // Write path registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_state_q <= WIdle;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      wr_busy_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_resp_q  <= RESP_OKAY;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      wr_busy_q  <= wr_busy_d;
      wr_done_q  <= wr_done_d;
      wr_resp_q  <= wr_resp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path state
  // ---------------------------------------------------------------------------
  rd_state_e               rd_state_q, rd_state_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rd_busy_q, rd_busy_d;
  logic                    rd_done_q, rd_done_d;
  logic [1:0]              rd_resp_q, rd_resp_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;

  // Read FSM next-state: address phase, then data phase, then a one-cycle done pulse.
  always_comb begin
    rd_state_d = rd_state_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    rd_busy_d  = rd_busy_q;
    rd_done_d  = 1'b0;
    rd_resp_d  = rd_resp_q;
    rd_data_d  = rd_data_q;
    araddr_d   = araddr_q;

    unique case (rd_state_q)
      RIdle: begin
        if (iRD_REQ) begin
          araddr_d   = iRD_ADDR;
          arvalid_d  = 1'b1;
          rd_busy_d  = 1'b1;
          rd_state_d = RAddr;
        end
      end
      RAddr: begin
        if (m_ARREADY) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = RData;
        end
      end
      RData: begin
        if (m_RVALID) begin
          rd_data_d  = m_RDATA;
          rd_resp_d  = m_RRESP;
          rready_d   = 1'b0;
          rd_busy_d  = 1'b0;
          rd_done_d  = 1'b1;
          rd_state_d = RIdle;
        end
      end
      default: begin
        rd_state_d = RIdle;
      end
    endcase
  end

  // Read path registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rd_state_q <= RIdle;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rd_busy_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_resp_q  <= RESP_OKAY;
      rd_data_q  <= '0;
      araddr_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      rd_busy_q  <= rd_busy_d;
      rd_done_q  <= rd_done_d;
      rd_resp_q  <= rd_resp_d;
      rd_data_q  <= rd_data_d;
      araddr_q   <= araddr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign oWR_BUSY  = wr_busy_q;
  assign oWR_DONE  = wr_done_q;
  assign oWR_RESP  = wr_resp_q;
  assign m_AWVALID = awvalid_q;
  assign m_AWADDR  = awaddr_q;
  assign m_AWPROT  = PROT;
  assign m_WVALID  = wvalid_q;
  assign m_WDATA   = wdata_q;
  assign m_WSTRB   = wstrb_q;
  assign m_BREADY  = bready_q;

  assign oRD_BUSY  = rd_busy_q;
  assign oRD_DONE  = rd_done_q;
  assign oRD_DATA  = rd_data_q;
  assign oRD_RESP  = rd_resp_q;
  assign m_ARVALID = arvalid_q;
  assign m_ARADDR  = araddr_q;
  assign m_ARPROT  = PROT;
  assign m_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: behavioural AXI4-Lite slave with stall/response knobs,
// scoreboard queues filled at command issue and drained when done pulses appear.
module tb_axi4_lite_master;

  logic        clk;
  logic        rst_n;

  logic        iWR_REQ;
  logic [31:0] iWR_ADDR;
  logic [31:0] iWR_DATA;
  logic [3:0]  iWR_STRB;
  logic        oWR_BUSY, oWR_DONE;
  logic [1:0]  oWR_RESP;
  logic        iRD_REQ;
  logic [31:0] iRD_ADDR;
  logic        oRD_BUSY, oRD_DONE;
  logic [31:0] oRD_DATA;
  logic [1:0]  oRD_RESP;

  logic        m_AWVALID, m_AWREADY;
  logic [31:0] m_AWADDR;
  logic [2:0]  m_AWPROT;
  logic        m_WVALID, m_WREADY;
  logic [31:0] m_WDATA;
  logic [3:0]  m_WSTRB;
  logic        m_BREADY, m_BVALID;
  logic [1:0]  m_BRESP;
  logic        m_ARVALID, m_ARREADY;
  logic [31:0] m_ARADDR;
  logic [2:0]  m_ARPROT;
  logic        m_RREADY, m_RVALID;
  logic [31:0] m_RDATA;
  logic [1:0]  m_RRESP;

  // Slave knobs
  logic        aw_rdy, w_rdy, ar_rdy, b_hold;
  logic [1:0]  cfg_bresp, cfg_rresp;

  int          n_checks;
  int          n_fail;
  int          wr_done_cnt;
  int          rd_done_cnt;

  logic [1:0]  wr_exp_q[$];
  logic [33:0] rd_exp_q[$];   // {data, resp}
  logic [31:0] model_mem [16];

  axi4_lite_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .PROT       (3'b000)
  ) dut (
    .iCLK      (clk),
    .iRST      (rst_n),
    .iWR_REQ   (iWR_REQ),
    .iWR_ADDR  (iWR_ADDR),
    .iWR_DATA  (iWR_DATA),
    .iWR_STRB  (iWR_STRB),
    .oWR_BUSY  (oWR_BUSY),
    .oWR_DONE  (oWR_DONE),
    .oWR_RESP  (oWR_RESP),
    .iRD_REQ   (iRD_REQ),
    .iRD_ADDR  (iRD_ADDR),
    .oRD_BUSY  (oRD_BUSY),
    .oRD_DONE  (oRD_DONE),
    .oRD_DATA  (oRD_DATA),
    .oRD_RESP  (oRD_RESP),
    .m_AWVALID (m_AWVALID),
    .m_AWADDR  (m_AWADDR),
    .m_AWPROT  (m_AWPROT),
    .m_AWREADY (m_AWREADY),
    .m_WVALID  (m_WVALID),
    .m_WDATA   (m_WDATA),
    .m_WSTRB   (m_WSTRB),
    .m_WREADY  (m_WREADY),
    .m_BREADY  (m_BREADY),
    .m_BVALID  (m_BVALID),
    .m_BRESP   (m_BRESP),
    .m_ARVALID (m_ARVALID),
    .m_ARADDR  (m_ARADDR),
    .m_ARPROT  (m_ARPROT),
    .m_ARREADY (m_ARREADY),
    .m_RREADY  (m_RREADY),
    .m_RVALID  (m_RVALID),
    .m_RDATA   (m_RDATA),
    .m_RRESP   (m_RRESP)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural slave: 16-word memory, AW/W captured independently, B once both seen.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [16];
  logic        got_aw, got_w;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;

  assign m_AWREADY = aw_rdy;
  assign m_WREADY  = w_rdy;
  assign m_ARREADY = ar_rdy;

  always @(posedge clk or negedge rst_n) begin
    logic        aw_ok, w_ok;
    logic [31:0] a, d;
    logic [3:0]  s;
    if (!rst_n) begin
      got_aw  <= 1'b0;
      got_w   <= 1'b0;
      m_BVALID <= 1'b0;
      m_BRESP  <= 2'b00;
      m_RVALID <= 1'b0;
      m_RDATA  <= 32'h0;
      m_RRESP  <= 2'b00;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else begin
      aw_ok = got_aw || (m_AWVALID && aw_rdy);
      w_ok  = got_w || (m_WVALID && w_rdy);
      a     = got_aw ? s_awaddr : m_AWADDR;
      d     = got_w ? s_wdata : m_WDATA;
      s     = got_w ? s_wstrb : m_WSTRB;
      if (m_AWVALID && aw_rdy) begin
        got_aw   <= 1'b1;
        s_awaddr <= m_AWADDR;
      end
      if (m_WVALID && w_rdy) begin
        got_w   <= 1'b1;
        s_wdata <= m_WDATA;
        s_wstrb <= m_WSTRB;
      end
      if (m_BVALID && m_BREADY) begin
        m_BVALID <= 1'b0;
      end else if (!m_BVALID && !b_hold && aw_ok && w_ok) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem[a[5:2]][8*b +: 8] <= d[8*b +: 8];
        m_BVALID <= 1'b1;
        m_BRESP  <= cfg_bresp;
        got_aw   <= 1'b0;
        got_w    <= 1'b0;
      end
      if (m_RVALID && m_RREADY) m_RVALID <= 1'b0;
      if (m_ARVALID && ar_rdy) begin
        m_RVALID <= 1'b1;
        m_RDATA  <= mem[m_ARADDR[5:2]];
        m_RRESP  <= cfg_rresp;
      end
    end
  end

  // Scoreboard drain: every done pulse pops and compares the oldest expectation.
  always @(negedge clk) begin
    logic [1:0]  we;
    logic [33:0] re;
    if (rst_n) begin
      if (oWR_DONE) begin
        wr_done_cnt++;
        n_checks++;
        if (wr_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_wr_unexpected: got done resp=%b, required no done", oWR_RESP);
        end else begin
          we = wr_exp_q.pop_front();
          if (oWR_RESP !== we) begin
            n_fail++;
            $display("FAIL sb_wr_resp: got %b, required %b", oWR_RESP, we);
          end
        end
      end
      if (oRD_DONE) begin
        rd_done_cnt++;
        n_checks++;
        if (rd_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_rd_unexpected: got done data=%h, required no done", oRD_DATA);
        end else begin
          re = rd_exp_q.pop_front();
          if ({oRD_DATA, oRD_RESP} !== re) begin
            n_fail++;
            $display("FAIL sb_rd_data_resp: got %h/%b, required %h/%b",
                     oRD_DATA, oRD_RESP, re[33:2], re[1:0]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive at negedge, return after one clock)
  // ---------------------------------------------------------------------------
  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
    iWR_ADDR = addr;
    iWR_DATA = data;
    iWR_STRB = strb;
    iWR_REQ  = 1'b1;
    wr_exp_q.push_back(resp);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
    @(negedge clk);
    iWR_REQ = 1'b0;
  endtask

  task automatic issue_read(input logic [31:0] addr, input logic [1:0] resp);
    iRD_ADDR = addr;
    iRD_REQ  = 1'b1;
    rd_exp_q.push_back({model_mem[addr[5:2]], resp});
    @(negedge clk);
    iRD_REQ = 1'b0;
  endtask

  // Waits for oWR_DONE; lat counts clocks from the request edge.
  task automatic wait_wr(output int lat);
    lat = 1;
    while (!oWR_DONE && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (!oWR_DONE) begin
      n_fail++;
      $display("FAIL wr_timeout: got no oWR_DONE in %0d cycles, required done", lat);
    end
  endtask

  task automatic wait_rd(output int lat);
    lat = 1;
    while (!oRD_DONE && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (!oRD_DONE) begin
      n_fail++;
      $display("FAIL rd_timeout: got no oRD_DONE in %0d cycles, required done", lat);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n   = 1'b0;
    iWR_REQ = 1'b1;
    iRD_REQ = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_channels: got %b, required 00000",
               {m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY});
    end
    n_checks++;
    if ({oWR_BUSY, oWR_DONE, oRD_BUSY, oRD_DONE} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_status: got %b, required 0000",
               {oWR_BUSY, oWR_DONE, oRD_BUSY, oRD_DONE});
    end
    n_checks++;
    if ({oWR_RESP, oRD_RESP, oRD_DATA} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_results: got %b/%b/%h, required 00/00/0", oWR_RESP, oRD_RESP,
               oRD_DATA);
    end
    n_checks++;
    if ({m_AWADDR, m_WDATA, m_WSTRB, m_ARADDR} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_payload: got %h %h %h %h, required zeros", m_AWADDR, m_WDATA,
               m_WSTRB, m_ARADDR);
    end
    iWR_REQ = 1'b0;
    iRD_REQ = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_basic;
    int lat;
    issue_write(32'h4, 32'hDEAD_BEEF, 4'hF, 2'b00);
    n_checks++;
    if ({m_AWVALID, m_WVALID, oWR_BUSY} !== 3'b111 || m_AWADDR !== 32'h4 ||
        m_WDATA !== 32'hDEAD_BEEF || m_AWPROT !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_issue: got v=%b addr=%h data=%h prot=%b, required 111/4/deadbeef/000",
               {m_AWVALID, m_WVALID, oWR_BUSY}, m_AWADDR, m_WDATA, m_AWPROT);
    end
    wait_wr(lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL wr_latency: got %0d, required 3", lat);
    end
    n_checks++;
    if (oWR_BUSY !== 1'b0 || m_BREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done_state: got busy=%b bready=%b, required 0/0", oWR_BUSY, m_BREADY);
    end
    @(negedge clk);
    n_checks++;
    if (oWR_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done_pulse: got %b one cycle later, required 0", oWR_DONE);
    end
  endtask

  task automatic test_read_basic;
    int lat;
    issue_read(32'h4, 2'b00);
    n_checks++;
    if (m_ARVALID !== 1'b1 || oRD_BUSY !== 1'b1 || m_ARADDR !== 32'h4) begin
      n_fail++;
      $display("FAIL rd_issue: got arvalid=%b busy=%b addr=%h, required 1/1/4", m_ARVALID,
               oRD_BUSY, m_ARADDR);
    end
    wait_rd(lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL rd_latency: got %0d, required 3", lat);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (oRD_DONE !== 1'b0 || oRD_DATA !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rd_hold: got done=%b data=%h, required 0/deadbeef", oRD_DONE, oRD_DATA);
    end
  endtask

  task automatic test_aw_stall;
    int lat;
    int start;
    start     = wr_done_cnt;
    aw_rdy    = 1'b0;
    cfg_bresp = 2'b10;
    issue_write(32'h10, 32'h1122_3344, 4'hF, 2'b10);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) aw_rdy = 1'b1;
      n_checks++;
      if (m_AWVALID !== 1'b1 || m_AWADDR !== 32'h10) begin
        n_fail++;
        $display("FAIL stall_aw_hold[%0d]: got v=%b addr=%h, required 1/10", k, m_AWVALID,
                 m_AWADDR);
      end
      @(negedge clk);
      n_checks++;
      if (m_WVALID !== 1'b0 || m_BREADY !== (k == 2)) begin
        n_fail++;
        $display("FAIL stall_w_first[%0d]: got wvalid=%b bready=%b, required 0/%0d", k,
                 m_WVALID, m_BREADY, (k == 2));
      end
    end
    wait_wr(lat);
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_done_cnt - start !== 1) begin
      n_fail++;
      $display("FAIL stall_done_count: got %0d, required 1", wr_done_cnt - start);
    end
    cfg_bresp = 2'b00;
  endtask

  task automatic test_strobe;
    int lat;
    issue_write(32'h4, 32'h1234_5678, 4'b0011, 2'b00);
    wait_wr(lat);
    @(negedge clk);
    issue_read(32'h4, 2'b00);
    wait_rd(lat);
    n_checks++;
    if (oRD_DATA !== 32'hDEAD_5678) begin
      n_fail++;
      $display("FAIL strobe_merge: got %h, required dead5678", oRD_DATA);
    end
    @(negedge clk);
  endtask

  task automatic test_concurrent;
    int ws, rs, n;
    int lat;
    ws = wr_done_cnt;
    rs = rd_done_cnt;
    iRD_ADDR = 32'h4;
    iRD_REQ  = 1'b1;
    rd_exp_q.push_back({model_mem[1], 2'b00});
    issue_write(32'h8, 32'hA5A5_A5A5, 4'hF, 2'b00);
    iRD_REQ = 1'b0;
    n_checks++;
    if (oWR_BUSY !== 1'b1 || oRD_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_both_busy: got wr=%b rd=%b, required 1/1", oWR_BUSY, oRD_BUSY);
    end
    // Second write while busy: must be dropped, so no expectation or model update.
    iWR_ADDR = 32'h8;
    iWR_DATA = 32'h0BAD_0BAD;
    iWR_REQ  = 1'b1;
    @(negedge clk);
    iWR_REQ = 1'b0;
    n = 0;
    while ((wr_done_cnt == ws || rd_done_cnt == rs) && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (wr_done_cnt - ws !== 1 || rd_done_cnt - rs !== 1) begin
      n_fail++;
      $display("FAIL conc_done_counts: got wr=%0d rd=%0d, required 1/1", wr_done_cnt - ws,
               rd_done_cnt - rs);
    end
    issue_read(32'h8, 2'b00);
    wait_rd(lat);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    int ws;
    int lat;
    b_hold = 1'b1;
    issue_write(32'hC, 32'h5555_AAAA, 4'hF, 2'b00);
    n = 0;
    while (!m_BREADY && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (m_BREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reach_resp: got bready=%b, required 1", m_BREADY);
    end
    ws    = wr_done_cnt;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_BREADY, oWR_BUSY, m_AWVALID, m_WVALID, oWR_DONE} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_async_drop: got %b, required 00000",
               {m_BREADY, oWR_BUSY, m_AWVALID, m_WVALID, oWR_DONE});
    end
    void'(wr_exp_q.pop_back());
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    b_hold = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (wr_done_cnt !== ws || oWR_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_done: got %0d dones busy=%b, required 0/0", wr_done_cnt - ws,
               oWR_BUSY);
    end
    issue_write(32'hC, 32'hCAFE_F00D, 4'hF, 2'b00);
    wait_wr(lat);
    @(negedge clk);
    cfg_rresp = 2'b11;
    issue_read(32'hC, 2'b11);
    wait_rd(lat);
    n_checks++;
    if (oRD_RESP !== 2'b11) begin
      n_fail++;
      $display("FAIL decerr_resp: got %b, required 11", oRD_RESP);
    end
    cfg_rresp = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk         = 1'b0;
    rst_n       = 1'b0;
    iWR_REQ     = 1'b0;
    iWR_ADDR    = '0;
    iWR_DATA    = '0;
    iWR_STRB    = '0;
    iRD_REQ     = 1'b0;
    iRD_ADDR    = '0;
    aw_rdy      = 1'b1;
    w_rdy       = 1'b1;
    ar_rdy      = 1'b1;
    b_hold      = 1'b0;
    cfg_bresp   = 2'b00;
    cfg_rresp   = 2'b00;
    n_checks    = 0;
    n_fail      = 0;
    wr_done_cnt = 0;
    rd_done_cnt = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    @(negedge clk);

    test_reset();
    test_write_basic();
    test_read_basic();
    test_aw_stall();
    test_strobe();
    test_concurrent();
    test_reset_mid();

    n_checks++;
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got wr=%0d rd=%0d pending, required 0/0", wr_exp_q.size(),
               rd_exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
